// File: rtl/ysyx_icache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ysyx_icache_pkg                                        |
// | Purpose : Shared ysyx constants for the instruction cache: FSM   |
// |           state encoding and the non-cacheable (MMIO) window.     |
// | Ports   : none (package)                                         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ysyx_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_BYPASS = 2'd2,
    ST_RESP   = 2'd3
  } icache_state_e;

  // Device window: fetches here go straight to the bus and are never cached.
  // Held as 64-bit values so any ADDR_W up to 64 compares without truncation.
  localparam logic [63:0] NC_BASE = 64'h0000_0000_1000_0000;
  localparam logic [63:0] NC_LAST = 64'h0000_0000_1FFF_FFFF;

  function automatic logic is_uncached(input logic [63:0] addr);
    return (addr >= NC_BASE) && (addr <= NC_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_icache_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ysyx_icache_array                                      |
// | Purpose : Direct-mapped line storage: valid bits, tags, words.    |
// |           One combinational read port, one write port, and a     |
// |           flash-clear of every valid bit.                        |
// | Ports   : clk, rst          - clock, sync active-high reset       |
// |           flash_clr         - clear all valid bits next edge      |
// |           rd_idx/rd_word    - read set / word select              |
// |           rd_valid/tag/data - read results (same cycle)           |
// |           wr_word_en ...    - write one data word                 |
// |           wr_tag_en, wr_tag - write tag and set valid for wr_idx  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ysyx_icache_array #(
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2,
  parameter int TAG_W     = 24,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flash_clr,
  input  logic [SET_BITS-1:0]  rd_idx,
  input  logic [WORD_BITS-1:0] rd_word,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 wr_word_en,
  input  logic [SET_BITS-1:0]  wr_idx,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_tag_en,
  input  logic [TAG_W-1:0]     wr_tag
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int LINES = 1 << (SET_BITS + WORD_BITS);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    // Flash-clear wins: a fence never coincides with a tag write, but if it
    // did the line must not survive the invalidate.
    if (flash_clr) begin
      valid_d = '0;
    end else if (wr_tag_en) begin
      valid_d[wr_idx] = 1'b1;
    end
    if (wr_tag_en) begin
      tag_d[wr_idx] = wr_tag;
    end
    if (wr_word_en) begin
      data_d[{wr_idx, wr_word}] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are don't-care until their valid bit is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_word}];

endmodule
`default_nettype wire

// File: rtl/ysyx_icache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ysyx_icache                                            |
// | Purpose : Direct-mapped instruction cache with in-order line      |
// |           refill, uncached bypass for the device window and       |
// |           fence_i invalidate-all.                                |
// | Ports   : clk, rst                 - clock, sync active-high reset|
// |           ifu_araddr/ifu_arvalid   - fetch request (held)         |
// |           ifu_rdata_o/ifu_rvalid_o - one-cycle fetch response     |
// |           fence_i                  - invalidate-all pulse         |
// |           bus_araddr_o/arvalid_o   - single-beat bus read request |
// |           bus_rdata/bus_rvalid     - bus read data beat           |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ysyx_icache
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] bus_araddr_o,
  output logic              bus_arvalid_o,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int OFF_W = WORD_BITS + 2;
  localparam int TAG_W = ADDR_W - SET_BITS - OFF_W;

  icache_state_e        state_q, state_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  logic                 fence_pend_q, fence_pend_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  // The request address is held stable by the IFU for the whole
  // transaction, so the refill address and write index come straight from it.
  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_idx;
  logic [WORD_BITS-1:0] req_word;
  logic                 req_uncached;

  assign req_tag      = ifu_araddr[ADDR_W-1 -: TAG_W];
  assign req_idx      = ifu_araddr[OFF_W +: SET_BITS];
  assign req_word     = ifu_araddr[2 +: WORD_BITS];
  assign req_uncached = is_uncached(64'(ifu_araddr));

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              last_beat;
  logic              flash_clr;
  logic              wr_word_en;
  logic              wr_tag_en;

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign last_beat = &cnt_q;

  ysyx_icache_array #(
    .SET_BITS  (SET_BITS),
    .WORD_BITS (WORD_BITS),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .flash_clr  (flash_clr),
    .rd_idx     (req_idx),
    .rd_word    (req_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_word_en (wr_word_en),
    .wr_idx     (req_idx),
    .wr_word    (cnt_q),
    .wr_data    (bus_rdata),
    .wr_tag_en  (wr_tag_en),
    .wr_tag     (req_tag)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fence_pend_q <= fence_pend_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic. A fence seen in IDLE suppresses the lookup for that
  // cycle so a held request is re-examined against the cleared array.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ifu_arvalid && !fence_i) begin
          if (req_uncached) begin
            state_d = ST_BYPASS;
          end else if (hit) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_REFILL: if (bus_rvalid && last_beat) state_d = ST_RESP;
      ST_BYPASS: if (bus_rvalid) state_d = ST_BYPASS == ST_BYPASS ? ST_RESP : ST_BYPASS;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and array controls.
  always_comb begin
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    fence_pend_d = fence_pend_q;
    flash_clr    = 1'b0;
    wr_word_en   = 1'b0;
    wr_tag_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fence_i) begin
          flash_clr = 1'b1;
        end else if (ifu_arvalid && !req_uncached) begin
          if (hit) begin
            rdata_d = rd_data;
          end else begin
            cnt_d = '0;
          end
        end
      end
      ST_REFILL: begin
        if (fence_i) fence_pend_d = 1'b1;
        if (bus_rvalid) begin
          wr_word_en = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          // Beats arrive word 0 first; grab the requested one as it passes.
          if (cnt_q == req_word) rdata_d = bus_rdata;
          if (last_beat) wr_tag_en = 1'b1;
        end
      end
      ST_BYPASS: begin
        if (fence_i)    fence_pend_d = 1'b1;
        if (bus_rvalid) rdata_d = bus_rdata;
      end
      ST_RESP: begin
        // Deferred invalidate lands on the edge back into IDLE, so the next
        // lookup already sees an empty array.
        flash_clr    = fence_pend_q || fence_i;
        fence_pend_d = 1'b0;
      end
      default: begin
        fence_pend_d = 1'b0;
      end
    endcase
  end

  // Outputs are a pure function of state; everything else is forced to zero.
  always_comb begin
    bus_arvalid_o = 1'b0;
    bus_araddr_o  = '0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    case (state_q)
      ST_REFILL: begin
        bus_arvalid_o = 1'b1;
        bus_araddr_o  = {req_tag, req_idx, cnt_q, 2'b00};
      end
      ST_BYPASS: begin
        bus_arvalid_o = 1'b1;
        bus_araddr_o  = ifu_araddr;
      end
      ST_RESP: begin
        ifu_rvalid_o = 1'b1;
        ifu_rdata_o  = rdata_q;
      end
      default: begin
        bus_arvalid_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_icache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ysyx_icache                                         |
// | Purpose : Self-checking bench for ysyx_icache: directed scenarios |
// |           followed by random fetches against a line-level model.  |
// | Ports   : none                                                   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_ysyx_icache;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        fence_i;
  logic [31:0] bus_araddr_o;
  logic        bus_arvalid_o;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [31:0] bus_log[$];
  bit          spurious_req = 0;

  // Reference model: which line (by tag) each set holds.
  bit          ref_valid [16];
  logic [23:0] ref_tag   [16];

  ysyx_icache #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .SET_BITS  (4),
    .WORD_BITS (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_araddr    (ifu_araddr),
    .ifu_arvalid   (ifu_arvalid),
    .ifu_rdata_o   (ifu_rdata_o),
    .ifu_rvalid_o  (ifu_rvalid_o),
    .fence_i       (fence_i),
    .bus_araddr_o  (bus_araddr_o),
    .bus_arvalid_o (bus_arvalid_o),
    .bus_rdata     (bus_rdata),
    .bus_rvalid    (bus_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents: a bijection of the address, so every word differs.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit uncached(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a <= 32'h1FFF_FFFF);
  endfunction

  task automatic model_fence();
    for (int s = 0; s < 16; s++) ref_valid[s] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus slave: answers each outstanding request after a random 0..2 cycle gap.
  initial begin
    int gap;
    gap        = 0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus_rvalid) begin
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        gap        = int'($urandom_range(0, 2));
      end else if (spurious_req && !bus_arvalid_o) begin
        bus_rvalid   = 1'b1;
        bus_rdata    = 32'hDEAD_BEEF;
        spurious_req = 1'b0;
      end else if (bus_arvalid_o && !rst) begin
        if (gap > 0) begin
          gap--;
        end else begin
          bus_rvalid = 1'b1;
          bus_rdata  = memval(bus_araddr_o);
          bus_log.push_back(bus_araddr_o);
        end
      end
    end
  end

  // Protocol watch: zeroed outputs when idle, single-cycle response pulse.
  initial begin
    bit prev_rvalid;
    prev_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!bus_arvalid_o && bus_araddr_o !== 32'h0) viol++;
        if (!ifu_rvalid_o && ifu_rdata_o !== 32'h0)   viol++;
        if (prev_rvalid && ifu_rvalid_o)              viol++;
      end
      prev_rvalid = ifu_rvalid_o;
    end
  end

  // fence_mode: 0 none, 1 fence together with the request, 2 fence mid-refill.
  task automatic do_fetch(input logic [31:0] addr, input int fence_mode, input string tag);
    logic [31:0] exp_q[$];
    int          idx;
    logic [23:0] atag;
    bit          hit_exp;
    bit          got;
    bit          fence_done;
    bit          seq_ok;
    int          lat;
    logic [31:0] data;

    idx        = int'(addr[7:4]);
    atag       = addr[31:8];
    hit_exp    = 1'b0;
    got        = 1'b0;
    fence_done = 1'b0;
    data       = '0;
    if (fence_mode == 1) model_fence();
    if (uncached(addr)) begin
      exp_q.push_back(addr);
    end else if (ref_valid[idx] && ref_tag[idx] == atag) begin
      hit_exp = 1'b1;
    end else begin
      for (int w = 0; w < 4; w++) exp_q.push_back({addr[31:4], 4'(w * 4)});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = atag;
    end

    bus_log.delete();
    @(negedge clk);
    ifu_araddr  = addr;
    ifu_arvalid = 1'b1;
    fence_i     = (fence_mode == 1);
    lat = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      fence_i = 1'b0;
      lat++;
      if (fence_mode == 2 && !fence_done && bus_log.size() >= 2) begin
        fence_i    = 1'b1;
        fence_done = 1'b1;
      end
      if (ifu_rvalid_o) begin
        got         = 1'b1;
        data        = ifu_rdata_o;
        ifu_arvalid = 1'b0;
      end
    end
    ifu_arvalid = 1'b0;
    @(negedge clk);
    fence_i = 1'b0;
    if (fence_done) model_fence();

    chk({tag, "_resp"}, 32'(got), 32'd1);
    chk({tag, "_data"}, data, memval(addr));
    chk({tag, "_nbus"}, 32'(bus_log.size()), 32'(exp_q.size()));
    seq_ok = (bus_log.size() == exp_q.size());
    if (seq_ok) begin
      for (int i = 0; i < exp_q.size(); i++) if (bus_log[i] !== exp_q[i]) seq_ok = 1'b0;
    end
    chk({tag, "_busseq"}, 32'(seq_ok), 32'd1);
    if (hit_exp) chk({tag, "_hitlat"}, 32'(lat), 32'd1);
  endtask

  task automatic idle_fence();
    @(negedge clk);
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    model_fence();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [31:0] a;
    int          r;

    rst         = 1'b1;
    ifu_araddr  = '0;
    ifu_arvalid = 1'b0;
    fence_i     = 1'b0;
    model_fence();
    repeat (3) @(negedge clk);
    chk("rst_rvalid",  32'(ifu_rvalid_o),  32'd0);
    chk("rst_rdata",   ifu_rdata_o,        32'd0);
    chk("rst_arvalid", 32'(bus_arvalid_o), 32'd0);
    chk("rst_araddr",  bus_araddr_o,       32'd0);
    rst = 1'b0;

    // Cold miss, hit on the refilled line, eviction by a conflicting tag.
    do_fetch(32'h8000_0008, 0, "cold");
    do_fetch(32'h8000_000C, 0, "rehit");
    do_fetch(32'h8000_0100, 0, "evict");
    do_fetch(32'h8000_0000, 0, "remiss");

    // Uncached window and its edges.
    do_fetch(32'h1000_0004, 0, "mmio1");
    do_fetch(32'h1000_0004, 0, "mmio2");
    do_fetch(32'h1FFF_FFFC, 0, "mmio_top");
    do_fetch(32'h0FFF_FFFC, 0, "below_mmio");
    do_fetch(32'h0FFF_FFF0, 0, "below_hit");

    // Fence variants.
    idle_fence();
    do_fetch(32'h8000_0004, 0, "idlefence");
    do_fetch(32'h8000_0008, 1, "fence_req");
    do_fetch(32'h8000_0204, 2, "fence_refill");
    do_fetch(32'h8000_0204, 0, "after_fence");

    // Stray bus beat while idle must not disturb the array.
    spurious_req = 1'b1;
    repeat (3) @(negedge clk);
    do_fetch(32'h8000_0200, 0, "spurious");

    // Reset in the middle of a refill.
    bus_log.delete();
    @(negedge clk);
    ifu_araddr  = 32'h8000_0040;
    ifu_arvalid = 1'b1;
    cnt = 0;
    while (bus_log.size() < 1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("rstmid_beat1", 32'(bus_log.size() >= 1), 32'd1);
    rst         = 1'b1;
    ifu_arvalid = 1'b0;
    @(negedge clk);
    chk("rstmid_arvalid", 32'(bus_arvalid_o), 32'd0);
    chk("rstmid_araddr",  bus_araddr_o,       32'd0);
    rst = 1'b0;
    model_fence();
    do_fetch(32'h8000_0040, 0, "rstmid_refetch");

    // Random traffic over a few conflicting tags plus the device window.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        a = 32'h1000_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end else begin
        a = {24'h80_0000 + 24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), 2'b00};
      end
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        idle_fence();
        do_fetch(a, 0, "rnd");
      end else if (r < 16) begin
        do_fetch(a, 1, "rnd_fq");
      end else if (r < 24) begin
        do_fetch(a, 2, "rnd_fr");
      end else begin
        do_fetch(a, 0, "rnd");
      end
    end

    chk("protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
